// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detectors: WIDTH-bit words in over
// valid/ready, one registered bit per clock out, with back-to-back words gapless.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             dataout,
  output logic             bit_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int          CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam bit          MSBF = (MSB_FIRST != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             last, accept;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] sreg_adv;

  assign last      = (state == SHIFT) && (bit_cnt == LAST);
  assign din_ready = ~abort & reset & ((state == IDLE) | last);
  assign accept    = din_valid & din_ready;
  assign busy      = (state == SHIFT);

  // sreg keeps the bit currently on dataout at its outgoing end
  assign first_bit = MSBF ? din[WIDTH-1]  : din[0];
  assign next_bit  = MSBF ? sreg[WIDTH-2] : sreg[1];
  assign sreg_adv  = MSBF ? (sreg << 1)   : (sreg >> 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      words_sent <= '0;
      dataout    <= IDLE_BIT;
      bit_valid  <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      dataout   <= IDLE_BIT;
      bit_valid <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      sreg       <= din;
      bit_cnt    <= '0;
      words_sent <= words_sent + 16'd1;
      dataout    <= first_bit;
      bit_valid  <= 1'b1;
    end else if (state == SHIFT) begin
      if (last) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        dataout   <= IDLE_BIT;
        bit_valid <= 1'b0;
      end else begin
        sreg    <= sreg_adv;
        bit_cnt <= bit_cnt + 1'b1;
        dataout <= next_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one MSB-first and one LSB-first instance,
// bit streams, back-to-back, abort, async reset mid-word and counter wrap.
module tb_serial_bit_feeder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  din, din_l;
  logic        din_valid, din_valid_l, abort, abort_l;
  logic        din_ready, dataout, bit_valid, busy;
  logic        din_ready_l, dataout_l, bit_valid_l, busy_l;
  logic [15:0] words_sent, words_sent_l;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ws = 0;

  always #5 clock = ~clock;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .abort(abort), .dataout(dataout),
    .bit_valid(bit_valid), .busy(busy), .words_sent(words_sent));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
    .clock(clock), .reset(reset), .din(din_l), .din_valid(din_valid_l),
    .din_ready(din_ready_l), .abort(abort_l), .dataout(dataout_l),
    .bit_valid(bit_valid_l), .busy(busy_l), .words_sent(words_sent_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Offer one word at a negedge, then check the 8 bits (exp_stream, first bit
  // in position 7) and the return to idle.
  task automatic xmit(input logic lsb, input logic [7:0] w, input logic [7:0] exp_stream,
                      input string tag);
    if (lsb) begin
      din_l = w; din_valid_l = 1'b1;
      chk({tag, "_rdy"}, 32'(din_ready_l), 32'd1);
    end else begin
      din = w; din_valid = 1'b1;
      chk({tag, "_rdy"}, 32'(din_ready), 32'd1);
    end
    @(negedge clock);
    din_valid = 1'b0; din_valid_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), 32'(lsb ? dataout_l : dataout), 32'(exp_stream[7-k]));
      chk($sformatf("%s_bv%0d", tag, k), 32'(lsb ? bit_valid_l : bit_valid), 32'd1);
      @(negedge clock);
    end
    chk({tag, "_idle_do"}, 32'(lsb ? dataout_l : dataout), 32'd0);
    chk({tag, "_idle_bv"}, 32'(lsb ? bit_valid_l : bit_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(lsb ? busy_l : busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    din = '0; din_l = '0; din_valid = 1'b0; din_valid_l = 1'b0;
    abort = 1'b0; abort_l = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_do", 32'(dataout), 32'd0);
    chk("rst_bv", 32'(bit_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(din_ready), 32'd0);
    chk("rst_ws", 32'(words_sent), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // single word, MSB first
    xmit(1'b0, 8'hE8, 8'hE8, "e8");
    exp_ws = 1;
    chk("e8_ws", 32'(words_sent), 32'(exp_ws));

    // back-to-back E8 then 1D with din_valid held high
    din = 8'hE8; din_valid = 1'b1;
    chk("b2b_rdy_idle", 32'(din_ready), 32'd1);
    @(negedge clock);
    din = 8'h1D;
    for (int k = 0; k < 16; k++) begin
      logic [15:0] s;
      s = 16'hE81D;
      chk($sformatf("b2b_bit%0d", k), 32'(dataout), 32'(s[15-k]));
      chk($sformatf("b2b_bv%0d", k), 32'(bit_valid), 32'd1);
      if (k < 8) chk($sformatf("b2b_rdy%0d", k), 32'(din_ready), 32'(k == 7));
      @(negedge clock);
      if (k == 7) din_valid = 1'b0;
    end
    chk("b2b_end_bv", 32'(bit_valid), 32'd0);
    chk("b2b_end_do", 32'(dataout), 32'd0);
    exp_ws += 2;
    chk("b2b_ws", 32'(words_sent), 32'(exp_ws));

    // LSB-first instance
    xmit(1'b1, 8'h17, 8'hE8, "lsb17");
    chk("lsb_ws", 32'(words_sent_l), 32'd1);

    // abort during bit 3
    din = 8'hFF; din_valid = 1'b1;
    @(negedge clock);
    din_valid = 1'b0;
    exp_ws++;
    repeat (3) @(negedge clock);
    chk("ab_bit3", 32'(dataout), 32'd1);
    abort = 1'b1;
    chk("ab_rdy", 32'(din_ready), 32'd0);
    @(negedge clock);
    abort = 1'b0;
    chk("ab_do", 32'(dataout), 32'd0);
    chk("ab_bv", 32'(bit_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ws", 32'(words_sent), 32'(exp_ws));

    // abort wins over din_valid in IDLE
    din = 8'h55; din_valid = 1'b1; abort = 1'b1;
    chk("abv_rdy", 32'(din_ready), 32'd0);
    @(negedge clock);
    din_valid = 1'b0; abort = 1'b0;
    chk("abv_busy", 32'(busy), 32'd0);
    chk("abv_bv", 32'(bit_valid), 32'd0);
    chk("abv_ws", 32'(words_sent), 32'(exp_ws));

    // asynchronous reset between edges while bit 5 is showing
    din = 8'h3C; din_valid = 1'b1;
    @(negedge clock);
    din_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("ar_bit5", 32'(dataout), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_do", 32'(dataout), 32'd0);
    chk("ar_bv", 32'(bit_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ws", 32'(words_sent), 32'd0);
    chk("ar_ws_l", 32'(words_sent_l), 32'd0);
    chk("ar_rdy", 32'(din_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    xmit(1'b0, 8'hA5, 8'hA5, "a5");
    exp_ws = 1;
    chk("a5_ws", 32'(words_sent), 32'(exp_ws));

    // counter wrap: preload near the top instead of sending 65k words
    force dut.words_sent = 16'hFFFE;
    #1 release dut.words_sent;
    @(negedge clock);
    chk("wr_pre", 32'(words_sent), 32'h0000FFFE);
    xmit(1'b0, 8'h81, 8'h81, "wr1");
    chk("wr_ffff", 32'(words_sent), 32'h0000FFFF);
    xmit(1'b0, 8'h42, 8'h42, "wr2");
    chk("wr_0000", 32'(words_sent), 32'h00000000);
    xmit(1'b0, 8'h0F, 8'h0F, "wr3");
    chk("wr_0001", 32'(words_sent), 32'h00000001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
